// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with built-in test-pattern source.
//
// Ports:
//   clock          system clock
//   i_reset        asynchronous active-low reset
//   i_pix_en       pixel strobe; every piece of state advances only when high
//   i_mode         pattern: 0 black, 1 colour bars, 2 checkerboard, 3 solid
//   i_solid_rgb    solid colour {R,G,B}
//   o_hsync/o_vsync, o_de, o_col/o_row, o_frame_start   registered timing
//   o_red/o_grn/o_blu                                   registered colour
//
// Outputs present the position held by the counters before each enable,
// so the first enable after reset presents (0,0).
module video_timing_pattern_gen #(
  parameter int SUB_PIXEL_WIDTH = 3,
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int HSYNC_POL       = 0,
  parameter int VSYNC_POL       = 0,
  parameter int CNT_WIDTH       = 12,
  parameter int CHECK_LOG2      = 5
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic                         i_pix_en,
  input  logic [1:0]                   i_mode,
  input  logic [3*SUB_PIXEL_WIDTH-1:0] i_solid_rgb,
  output logic                         o_hsync,
  output logic                         o_vsync,
  output logic                         o_de,
  output logic [CNT_WIDTH-1:0]         o_col,
  output logic [CNT_WIDTH-1:0]         o_row,
  output logic                         o_frame_start,
  output logic [SUB_PIXEL_WIDTH-1:0]   o_red,
  output logic [SUB_PIXEL_WIDTH-1:0]   o_grn,
  output logic [SUB_PIXEL_WIDTH-1:0]   o_blu
);
  localparam int SPW     = SUB_PIXEL_WIDTH;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_WIDTH-1:0] H_LAST  = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST  = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_ACT   = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_ACT   = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] HS_BEG  = CNT_WIDTH'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_WIDTH-1:0] HS_END  = CNT_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] VS_BEG  = CNT_WIDTH'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_WIDTH-1:0] VS_END  = CNT_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_WIDTH-1:0] BAR_END = CNT_WIDTH'(BAR_W - 1);
  localparam logic                 HS_ON   = (HSYNC_POL != 0);
  localparam logic                 VS_ON   = (VSYNC_POL != 0);
  localparam logic [SPW-1:0]       FS      = {SPW{1'b1}};

  typedef enum logic [1:0] {PAT_BLACK, PAT_BARS, PAT_CHECK, PAT_SOLID} pattern_t;

  logic [CNT_WIDTH-1:0] col, row, bar_pos;
  logic [2:0]           bar_idx;
  pattern_t             sh_mode, eff_mode;
  logic [3*SPW-1:0]     sh_rgb, eff_rgb;
  logic                 origin, de_n, hs_n, vs_n;
  logic [2:0]           bar_c;
  logic [SPW-1:0]       r_n, g_n, b_n;

  // Position counters plus a running bar counter that tracks col / BAR_W
  // (saturating at bar 7) without a divider.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      col     <= '0;
      row     <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (i_pix_en) begin
      if (col == H_LAST) begin
        col     <= '0;
        row     <= (row == V_LAST) ? '0 : row + 1'b1;
        bar_pos <= '0;
        bar_idx <= '0;
      end else begin
        col <= col + 1'b1;
        if (bar_pos == BAR_END) begin
          bar_pos <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pos <= bar_pos + 1'b1;
        end
      end
    end
  end

  // The frame's first pixel already uses the freshly sampled mode/colour,
  // so it bypasses the shadow registers on that one enable.
  assign origin   = (col == '0) && (row == '0);
  assign eff_mode = origin ? pattern_t'(i_mode) : sh_mode;
  assign eff_rgb  = origin ? i_solid_rgb : sh_rgb;
  assign de_n     = (col < H_ACT) && (row < V_ACT);
  assign hs_n     = (col >= HS_BEG && col < HS_END) ? HS_ON : ~HS_ON;
  assign vs_n     = (row >= VS_BEG && row < VS_END) ? VS_ON : ~VS_ON;
  assign bar_c    = 3'd7 - bar_idx;

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (de_n) begin
      case (eff_mode)
        PAT_BARS: begin
          g_n = bar_c[2] ? FS : '0;
          r_n = bar_c[1] ? FS : '0;
          b_n = bar_c[0] ? FS : '0;
        end
        PAT_CHECK: begin
          if (col[CHECK_LOG2] ^ row[CHECK_LOG2]) begin
            r_n = FS;
            g_n = FS;
            b_n = FS;
          end
        end
        PAT_SOLID: begin
          r_n = eff_rgb[3*SPW-1:2*SPW];
          g_n = eff_rgb[2*SPW-1:SPW];
          b_n = eff_rgb[SPW-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sh_mode       <= PAT_BLACK;
      sh_rgb        <= '0;
      o_hsync       <= ~HS_ON;
      o_vsync       <= ~VS_ON;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_col         <= '0;
      o_row         <= '0;
      o_red         <= '0;
      o_grn         <= '0;
      o_blu         <= '0;
    end else if (i_pix_en) begin
      if (origin) begin
        sh_mode <= pattern_t'(i_mode);
        sh_rgb  <= i_solid_rgb;
      end
      o_hsync       <= hs_n;
      o_vsync       <= vs_n;
      o_de          <= de_n;
      o_frame_start <= origin;
      o_col         <= col;
      o_row         <= row;
      o_red         <= r_n;
      o_grn         <= g_n;
      o_blu         <= b_n;
    end
  end
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen: instance 0 uses the 640x480 default
// timing, instance 1 a small 80x30 raster with active-high hsync so whole
// frames fit in a short run. A behavioural model pushes the expected pixel
// on every enable; the entry is popped and compared once the DUT presents it.
module tb_video_timing_pattern_gen;
  typedef struct packed {
    logic        hs, vs, de, fs;
    logic [11:0] col, row;
    logic [2:0]  r, g, b;
  } out_t;

  localparam int HA [2] = '{640, 64};
  localparam int HF [2] = '{16, 4};
  localparam int HS [2] = '{96, 8};
  localparam int HB [2] = '{48, 4};
  localparam int VA [2] = '{480, 24};
  localparam int VF [2] = '{10, 2};
  localparam int VS [2] = '{2, 2};
  localparam int VB [2] = '{33, 2};
  localparam int HP [2] = '{0, 1};
  localparam int VP [2] = '{0, 0};
  localparam int CK [2] = '{5, 2};

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_pix_en = 1'b0;
  logic [1:0] i_mode = 2'd0;
  logic [8:0] i_solid_rgb = '0;

  logic a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
  logic [11:0] a_col, a_row, b_col, b_row;
  logic [2:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  out_t obs [2];

  always #5 clock = ~clock;

  video_timing_pattern_gen dut_a (
    .clock(clock), .i_reset(i_reset), .i_pix_en(i_pix_en), .i_mode(i_mode),
    .i_solid_rgb(i_solid_rgb), .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
    .o_col(a_col), .o_row(a_row), .o_frame_start(a_fs),
    .o_red(a_r), .o_grn(a_g), .o_blu(a_b));

  video_timing_pattern_gen #(
    .H_ACTIVE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(24), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1), .VSYNC_POL(0), .CHECK_LOG2(2)
  ) dut_b (
    .clock(clock), .i_reset(i_reset), .i_pix_en(i_pix_en), .i_mode(i_mode),
    .i_solid_rgb(i_solid_rgb), .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
    .o_col(b_col), .o_row(b_row), .o_frame_start(b_fs),
    .o_red(b_r), .o_grn(b_g), .o_blu(b_b));

  assign obs[0] = {a_hs, a_vs, a_de, a_fs, a_col, a_row, a_r, a_g, a_b};
  assign obs[1] = {b_hs, b_vs, b_de, b_fs, b_col, b_row, b_r, b_g, b_b};

  int errors = 0;
  int checks = 0;
  int n_en = 0;
  int cnt_hs_a = 0, cnt_hs_b = 0, cnt_vs_b = 0, cnt_fs_b = 0;
  int mc [2], mr [2], smode [2];
  logic [8:0] srgb [2];
  out_t last [2];
  out_t qa [$];
  out_t qb [$];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic out_t reset_out(int d);
    out_t o;
    o = '0;
    o.hs = (HP[d] == 0);
    o.vs = (VP[d] == 0);
    return o;
  endfunction

  function automatic out_t model_px(int d, int c, int r, int m, logic [8:0] rgb);
    out_t o;
    int bi, cc;
    o     = '0;
    o.col = 12'(c);
    o.row = 12'(r);
    o.de  = (c < HA[d]) && (r < VA[d]);
    o.fs  = (c == 0) && (r == 0);
    o.hs  = (c >= HA[d] + HF[d] && c < HA[d] + HF[d] + HS[d]) ? (HP[d] != 0) : (HP[d] == 0);
    o.vs  = (r >= VA[d] + VF[d] && r < VA[d] + VF[d] + VS[d]) ? (VP[d] != 0) : (VP[d] == 0);
    if (o.de) begin
      case (m)
        1: begin
          bi = c / (HA[d] / 8);
          if (bi > 7) bi = 7;
          cc = 7 - bi;
          o.g = cc[2] ? 3'd7 : 3'd0;
          o.r = cc[1] ? 3'd7 : 3'd0;
          o.b = cc[0] ? 3'd7 : 3'd0;
        end
        2: if ((((c >> CK[d]) ^ (r >> CK[d])) & 1) == 1) begin
          o.r = 3'd7; o.g = 3'd7; o.b = 3'd7;
        end
        3: begin o.r = rgb[8:6]; o.g = rgb[5:3]; o.b = rgb[2:0]; end
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mc[d] = 0; mr[d] = 0; smode[d] = 0; srgb[d] = '0;
      last[d] = reset_out(d);
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_step(int d);
    out_t e;
    if (mc[d] == 0 && mr[d] == 0) begin
      smode[d] = int'(i_mode);
      srgb[d]  = i_solid_rgb;
    end
    e = model_px(d, mc[d], mr[d], smode[d], srgb[d]);
    if (d == 0) qa.push_back(e); else qb.push_back(e);
    if (mc[d] == HA[d] + HF[d] + HS[d] + HB[d] - 1) begin
      mc[d] = 0;
      mr[d] = (mr[d] == VA[d] + VF[d] + VS[d] + VB[d] - 1) ? 0 : mr[d] + 1;
    end else begin
      mc[d] = mc[d] + 1;
    end
  endtask

  // One clock; on enable cycles the model predicts, otherwise outputs must hold.
  task automatic tick(input bit en);
    i_pix_en = en;
    if (en) begin
      model_step(0);
      model_step(1);
    end
    @(posedge clock);
    #1;
    if (en) begin
      n_en++;
      if (qa.size() == 0 || qb.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        last[0] = qa.pop_front();
        last[1] = qb.pop_front();
      end
      if (a_hs == 1'b0) cnt_hs_a++;
      if (b_hs == 1'b1) cnt_hs_b++;
      if (b_vs == 1'b0) cnt_vs_b++;
      if (b_fs == 1'b1) cnt_fs_b++;
    end
    chk(en ? "pix_a" : "hold_a", obs[0], last[0]);
    chk(en ? "pix_b" : "hold_b", obs[1], last[1]);
  endtask

  initial begin
    model_reset();
    i_mode = 2'd1;
    for (int i = 0; i < 3; i++) tick(0);
    i_reset = 1'b1;
    for (int i = 0; i < 700; i++) tick(1);

    // asynchronous reset in the middle of a line
    i_reset = 1'b0;
    #1;
    model_reset();
    chk("rst_a", obs[0], reset_out(0));
    chk("rst_b", obs[1], reset_out(1));
    chk("rst_a_hsync_high", a_hs, 1'b1);
    chk("rst_b_hsync_low", b_hs, 1'b0);
    tick(0);
    tick(0);
    i_reset = 1'b1;
    n_en = 0; cnt_hs_a = 0; cnt_hs_b = 0; cnt_vs_b = 0; cnt_fs_b = 0;

    tick(1);
    chk("first_col", a_col, 12'd0);
    chk("first_row", a_row, 12'd0);
    chk("first_fs", a_fs, 1'b1);
    chk("first_de", a_de, 1'b1);
    chk("bar_col0", {a_r, a_g, a_b}, {3'd7, 3'd7, 3'd7});

    for (int i = 1; i < 1600; i++) begin
      tick(1);
      if (i == 80)  chk("bar_col80", {a_r, a_g, a_b}, {3'd7, 3'd7, 3'd0});
      if (i == 160) chk("bar_col160", {a_r, a_g, a_b}, {3'd0, 3'd7, 3'd7});
      if (i == 600) chk("bar_col600", {a_r, a_g, a_b}, {3'd0, 3'd0, 3'd0});
      if (i == 639) chk("de_col639", a_de, 1'b1);
      if (i == 640) chk("de_col640", a_de, 1'b0);
      if (i == 655) chk("hs_col655", a_hs, 1'b1);
      if (i == 656) chk("hs_col656", a_hs, 1'b0);
      if (i == 751) chk("hs_col751", a_hs, 1'b0);
      if (i == 752) chk("hs_col752", a_hs, 1'b1);
      if (i == 800) chk("wrap_row", {a_col, a_row}, {12'd0, 12'd1});
    end
    chk("hs_low_count_a", cnt_hs_a, 192);
    chk("hs_high_count_b", cnt_hs_b, 160);

    // mid-frame switch to solid colour; takes effect at the next frame only
    i_mode = 2'd3;
    i_solid_rgb = {3'd5, 3'd2, 3'd1};
    while (n_en < 2400) tick(1);
    chk("vs_count_b", cnt_vs_b, 160);
    chk("fs_count_b", cnt_fs_b, 1);
    chk("b_last_row", b_row, 12'd29);
    tick(1);
    chk("solid_next_frame", {b_r, b_g, b_b}, {3'd5, 3'd2, 3'd1});
    chk("b_row_wrap", {b_col, b_row, b_fs}, {12'd0, 12'd0, 1'b1});
    chk("fs_count_b2", cnt_fs_b, 2);
    chk("a_bars_continue", {a_r, a_g, a_b}, {3'd7, 3'd7, 3'd7});

    // sparse and stalled enables: timing advances in enables, not clocks
    for (int i = 0; i < 400; i++) tick((i % 4) == 0);
    for (int i = 0; i < 10; i++) tick(0);
    chk("a_col_after_duty", a_col, 12'd100);

    i_mode = 2'd2;
    while (n_en < 4800) tick(1);
    tick(1);
    chk("check_origin_black", {b_r, b_g, b_b}, 9'd0);
    for (int i = 0; i < 4; i++) tick(1);
    chk("check_col4_white", {b_r, b_g, b_b}, 9'h1ff);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/video_timing_pattern_gen.md
Name: video_timing_pattern_gen

Overview:
- Parametrised raster timing generator with a built-in test-pattern source for the display path.
- Produces horizontal and vertical syncs, data-enable, column and row coordinates, a frame-start marker, and per-channel pixel colour of SUB_PIXEL_WIDTH bits.
- Sits between the pixel-clock-enable source and the video output pins.
- Replaces a hand-wired fixed-640x480 sync/count path with a generic, mode-selectable block.

Parameters:
- SUB_PIXEL_WIDTH, 3: bits per colour channel.
- H_ACTIVE, 640: visible columns.
- H_FRONT, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BACK, 48: horizontal back porch.
- V_ACTIVE, 480: visible rows.
- V_FRONT, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BACK, 33: vertical back porch.
- HSYNC_POL, 0: asserted level of o_hsync (0 = active-low).
- VSYNC_POL, 0: asserted level of o_vsync.
- CNT_WIDTH, 12: width of the coordinate counters; must hold H_TOTAL-1 and V_TOTAL-1.
- CHECK_LOG2, 5: checkerboard cell size is 2^CHECK_LOG2 pixels.

Ports:
- clock, in, 1: system clock.
- i_reset, in, 1: asynchronous, active-low reset.
- i_pix_en, in, 1: pixel strobe; all state advances only on cycles where it is high.
- i_mode, in, 2: pattern select. 0 = black, 1 = colour bars, 2 = checkerboard, 3 = solid.
- i_solid_rgb, in, 3*SUB_PIXEL_WIDTH: solid colour as {R,G,B}.
- o_hsync, out, 1: horizontal sync.
- o_vsync, out, 1: vertical sync.
- o_de, out, 1: high in the active region.
- o_col, out, CNT_WIDTH: column of the presented pixel.
- o_row, out, CNT_WIDTH: row of the presented pixel.
- o_frame_start, out, 1: high while pixel (0,0) is presented.
- o_red, out, SUB_PIXEL_WIDTH: red channel.
- o_grn, out, SUB_PIXEL_WIDTH: green channel.
- o_blu, out, SUB_PIXEL_WIDTH: blue channel.

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (800 by default). V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK (525 by default). BAR_W = H_ACTIVE/8, integer division.
- Internal col/row counters are reset to 0. On each i_pix_en cycle:
  - col increments.
  - When col == H_TOTAL-1, col wraps to 0 and row increments.
  - When row == V_TOTAL-1 at the same time, row also wraps to 0.
- All outputs are registered and update only on i_pix_en cycles. Between enables they hold.
- On an enable edge, outputs present the position held by the counters before that edge. Latency is 1 enable: the first i_pix_en after reset presents (0,0).
- Output decode for the presented position:
  - o_de = (col < H_ACTIVE) && (row < V_ACTIVE).
  - o_hsync = HSYNC_POL when H_ACTIVE+H_FRONT <= col < H_ACTIVE+H_FRONT+H_SYNC; otherwise ~HSYNC_POL. Default window is cols 656..751.
  - o_vsync = VSYNC_POL when V_ACTIVE+V_FRONT <= row < V_ACTIVE+V_FRONT+V_SYNC; otherwise ~VSYNC_POL. Default window is rows 490..491. The vsync window is row-based and ignores col.
  - o_frame_start = (col == 0 && row == 0).
- Mode and solid colour are latched into shadow registers on the enable that presents (0,0). The latched values apply from pixel (0,0) of that frame for the whole frame. Mid-frame changes to i_mode or i_solid_rgb have no effect until the next frame. At reset, the shadow registers are mode 0 and colour 0.
- Colours are all zeros whenever o_de = 0. When o_de = 1, colour depends on the latched mode (FS = all ones of SUB_PIXEL_WIDTH):
  - Mode 0: all zeros.
  - Mode 1: bar index i = min(col / BAR_W, 7); let c = 7 - i. Then G = c[2] ? FS : 0, R = c[1] ? FS : 0, B = c[0] ? FS : 0. This gives white, yellow, cyan, green, magenta, red, blue, black. A running bar counter is an acceptable implementation; no divider is required.
  - Mode 2: all channels = FS if col[CHECK_LOG2] ^ row[CHECK_LOG2] is 1, else 0.
  - Mode 3: the latched {R,G,B}.
- Reset values, asserted asynchronously:
  - Counters 0.
  - o_hsync = ~HSYNC_POL, o_vsync = ~VSYNC_POL.
  - o_de = 0, o_frame_start = 0.
  - o_col = 0, o_row = 0.
  - All colours 0.
- Reset mid-frame restarts from (0,0). No partial state is retained.
- i_pix_en held low freezes all state and outputs indefinitely.
- Back-to-back enables are legal every clock.

Test Plan:
1. Assert i_reset low mid-line at default params -> immediately o_hsync = 1, o_vsync = 1, o_de = 0, colours 0. After release, the first i_pix_en gives o_col = 0, o_row = 0, o_frame_start = 1, o_de = 1.
2. Continuous i_pix_en, default params -> o_hsync low for exactly 96 enables starting at o_col = 656. o_de is high for o_col 0..639 and low for 640..799. Col wraps 799 -> 0 with row+1.
3. Full frame -> o_vsync low exactly on rows 490..491. o_frame_start is high once per 420000 enables. Row wraps 524 -> 0.
4. Mode 1, SUB_PIXEL_WIDTH = 3 -> at col 0 RGB = 7/7/7; col 80 = 7/7/0; col 160 = 0/7/7; col 560..639 = 0/0/0. Mode 2 -> col 32, row 0 is white; col 32, row 32 is black.
5. Switch i_mode 1 -> 3 with i_solid_rgb = {3'd5,3'd2,3'd1} at row 100 -> bars continue to the end of the frame. The next frame (0,0) shows 5/2/1.
6. Toggle i_pix_en with 1-in-4 duty, and separately hold it low for 10 clocks -> outputs change only on enable cycles and the timing counts in enables. Then HSYNC_POL = 1 -> o_hsync is high only on cols 656..751.
